// File: rtl/cfr_pa_pkg.sv
// cfr_pkg: definitions shared by the CFR peak allocator.
//   - Default values of the cfr_pa parameters.
//   - slot_cnt_width(): width of a slot counter that holds PULSE_LEN.
//   - SLOT_CNT_W: slot counter width for the default PULSE_LEN.
//   - peak_t: a peak record {r, theta, phase}. Its fields use the default
//     DATA_WIDTH/ITERATIONS, so cfr_pa must be built at those widths.
package cfr_pkg;

  localparam int DEF_ITERATIONS = 7;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_PULSE_LEN  = 64;

  function automatic int slot_cnt_width(input int pulse_len);
    return $clog2(pulse_len + 1);
  endfunction

  localparam int SLOT_CNT_W = $clog2(DEF_PULSE_LEN + 1);

  typedef struct packed {
    logic [DEF_DATA_WIDTH:0] r;
    logic [DEF_ITERATIONS:0] theta;
    logic                    phase;
  } peak_t;

endpackage

// File: rtl/cfr_pa_slot.sv
// cfr_pa_slot: busy timer for one cancellation pulse generator slot.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   start      - loads the counter with PULSE_LEN
//   busy       - the counter is non-zero
//   idle_next  - the counter will read 0 next cycle if no start arrives,
//                so a start issued on the next edge is legal
module cfr_pa_slot
  import cfr_pkg::*;
#(
  parameter int PULSE_LEN = DEF_PULSE_LEN,
  parameter int CNT_W     = SLOT_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic idle_next
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(PULSE_LEN);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

  // The start register and the counter load on the same edge. A slot whose
  // counter shows 1 reaches 0 exactly PULSE_LEN cycles after its previous
  // start, so that is the cycle in which it may start again.
  assign idle_next = (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/cfr_pa.sv
// cfr_pa: peak-to-CPG allocator for crest factor reduction.
// Stage 1 qualifies the incoming peak and computes the clipped amplitude.
// Stage 2 hands the peak to the lowest free slot, or drops it if every slot
// is busy. cpg_start follows peak_valid by exactly 2 cycles.
// Ports:
//   clk, rst                      - clock and synchronous active-high reset
//   peak_r/theta/phase/valid      - detected peak (magnitude, angle, sample phase)
//   cpg_start                     - one-hot start strobe to a slot
//   cpg_amp/theta/phase           - pulse parameters, zero when no start
//   ctrl_enable                   - allocation enable
//   ctrl_pd_threshold             - peak detection threshold
//   ctrl_clipping_threshold       - clipping level subtracted from peak_r
//   stat_busy                     - per-slot busy flags
//   stat_drop_cnt, stat_drop_clr  - saturating count of dropped peaks, and its clear
// Build option: define CFR_PA_DROP_CNT_EN to include the drop counter. Without
// it, stat_drop_cnt reads 0 and stat_drop_clr has no effect.
module cfr_pa
  import cfr_pkg::*;
#(
  parameter int ITERATIONS = 7,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CPG    = 4,
  parameter int PULSE_LEN  = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_WIDTH:0] peak_r,
  input  logic [ITERATIONS:0] peak_theta,
  input  logic                peak_phase,
  input  logic                peak_valid,
  output logic [NUM_CPG-1:0]  cpg_start,
  output logic [DATA_WIDTH:0] cpg_amp,
  output logic [ITERATIONS:0] cpg_theta,
  output logic                cpg_phase,
  input  logic                ctrl_enable,
  input  logic [DATA_WIDTH:0] ctrl_pd_threshold,
  input  logic [DATA_WIDTH:0] ctrl_clipping_threshold,
  output logic [NUM_CPG-1:0]  stat_busy,
  output logic [15:0]         stat_drop_cnt,
  input  logic                stat_drop_clr
);

  localparam int CNT_W = slot_cnt_width(PULSE_LEN);

  logic                s1_valid_q, s1_valid_d;
  peak_t               s1_peak_q, s1_peak_d;
  logic [DATA_WIDTH:0] amp;

  logic [NUM_CPG-1:0]  cpg_start_q, cpg_start_d;
  logic [DATA_WIDTH:0] cpg_amp_q, cpg_amp_d;
  logic [ITERATIONS:0] cpg_theta_q, cpg_theta_d;
  logic                cpg_phase_q, cpg_phase_d;

  logic [NUM_CPG-1:0]  slot_idle_next;
  logic                found;
  logic                drop;

  // Stage 1: qualify the peak and clip it. A peak at or below the clipping
  // level has nothing to cancel; it is discarded here and never counted as a drop.
  always_comb begin
    amp        = '0;
    s1_valid_d = 1'b0;
    s1_peak_d  = '0;
    if (peak_r > ctrl_clipping_threshold) begin
      amp = peak_r - ctrl_clipping_threshold;
    end
    if (peak_valid && ctrl_enable && (peak_r > ctrl_pd_threshold) && (amp != '0)) begin
      s1_valid_d      = 1'b1;
      s1_peak_d.r     = amp;
      s1_peak_d.theta = peak_theta;
      s1_peak_d.phase = peak_phase;
    end
  end

  // Stage 2: the lowest-index slot that is free in the start cycle wins.
  always_comb begin
    cpg_start_d = '0;
    cpg_amp_d   = '0;
    cpg_theta_d = '0;
    cpg_phase_d = 1'b0;
    found       = 1'b0;
    for (int i = 0; i < NUM_CPG; i++) begin
      if (s1_valid_q && !found && slot_idle_next[i]) begin
        cpg_start_d[i] = 1'b1;
        found          = 1'b1;
      end
    end
    if (found) begin
      cpg_amp_d   = s1_peak_q.r;
      cpg_theta_d = s1_peak_q.theta;
      cpg_phase_d = s1_peak_q.phase;
    end
    drop = s1_valid_q && !found;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_peak_q   <= '0;
      cpg_start_q <= '0;
      cpg_amp_q   <= '0;
      cpg_theta_q <= '0;
      cpg_phase_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_peak_q   <= s1_peak_d;
      cpg_start_q <= cpg_start_d;
      cpg_amp_q   <= cpg_amp_d;
      cpg_theta_q <= cpg_theta_d;
      cpg_phase_q <= cpg_phase_d;
    end
  end

  assign cpg_start = cpg_start_q;
  assign cpg_amp   = cpg_amp_q;
  assign cpg_theta = cpg_theta_q;
  assign cpg_phase = cpg_phase_q;

  // Each slot loads on the same edge that raises its cpg_start bit.
  for (genvar i = 0; i < NUM_CPG; i++) begin : g_slot
    cfr_pa_slot #(
      .PULSE_LEN (PULSE_LEN),
      .CNT_W     (CNT_W)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .start     (cpg_start_d[i]),
      .busy      (stat_busy[i]),
      .idle_next (slot_idle_next[i])
    );
  end

`ifdef CFR_PA_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // A clear wins over an increment in the same cycle.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (stat_drop_clr) begin
      drop_cnt_d = '0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign stat_drop_cnt = drop_cnt_q;
`else
  logic unused_drop;
  assign unused_drop   = drop ^ stat_drop_clr;
  assign stat_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_cfr_pa.sv
// Self-checking bench for cfr_pa. The reference model works on a timeline.
// A qualified peak driven in cycle c is due to start in cycle c+2. It goes to
// the lowest slot whose previous pulse began at least PULSE_LEN cycles before
// that. From those decisions the model fills per-cycle arrays of expected
// outputs, which are compared with the DUT on every falling edge.
module tb_cfr_pa;

  localparam int IT   = 7;
  localparam int DW   = 16;
  localparam int NC   = 4;
  localparam int PL   = 64;
  localparam int MAXC = 80000;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW:0]   peak_r;
  logic [IT:0]   peak_theta;
  logic          peak_phase;
  logic          peak_valid;
  logic [NC-1:0] cpg_start;
  logic [DW:0]   cpg_amp;
  logic [IT:0]   cpg_theta;
  logic          cpg_phase;
  logic          ctrl_enable;
  logic [DW:0]   ctrl_pd_threshold;
  logic [DW:0]   ctrl_clipping_threshold;
  logic [NC-1:0] stat_busy;
  logic [15:0]   stat_drop_cnt;
  logic          stat_drop_clr;

  always #5 clk = ~clk;

  cfr_pa #(
    .ITERATIONS (IT),
    .DATA_WIDTH (DW),
    .NUM_CPG    (NC),
    .PULSE_LEN  (PL)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .peak_r                  (peak_r),
    .peak_theta              (peak_theta),
    .peak_phase              (peak_phase),
    .peak_valid              (peak_valid),
    .cpg_start               (cpg_start),
    .cpg_amp                 (cpg_amp),
    .cpg_theta               (cpg_theta),
    .cpg_phase               (cpg_phase),
    .ctrl_enable             (ctrl_enable),
    .ctrl_pd_threshold       (ctrl_pd_threshold),
    .ctrl_clipping_threshold (ctrl_clipping_threshold),
    .stat_busy               (stat_busy),
    .stat_drop_cnt           (stat_drop_cnt),
    .stat_drop_clr           (stat_drop_clr)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int m_drop   = 0;
  int next_free [NC];

  bit [NC-1:0] exp_start [MAXC];
  bit [DW:0]   exp_amp   [MAXC];
  bit [IT:0]   exp_theta [MAXC];
  bit          exp_phase [MAXC];
  bit [NC-1:0] exp_busy  [MAXC];
  bit          drop_evt  [MAXC];
  bit          clr_evt   [MAXC];
  bit          rst_evt   [MAXC];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=0x%0h expected=0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int exp_drop_cnt();
`ifdef CFR_PA_DROP_CNT_EN
    return m_drop;
`else
    return 0;
`endif
  endfunction

  // Record what the inputs of cycle c imply for later cycles.
  task automatic model(input int c);
    int          s;
    bit          found;
    bit [NC-1:0] one;
    one = 1;
    if (rst) begin
      for (int k = c + 1; k < MAXC; k++) begin
        exp_start[k] = '0;
        exp_amp[k]   = '0;
        exp_theta[k] = '0;
        exp_phase[k] = 1'b0;
        exp_busy[k]  = '0;
        drop_evt[k]  = 1'b0;
        clr_evt[k]   = 1'b0;
      end
      rst_evt[c + 1] = 1'b1;
      for (int i = 0; i < NC; i++) next_free[i] = 0;
      return;
    end
    if (stat_drop_clr) clr_evt[c + 1] = 1'b1;
    if (peak_valid && ctrl_enable && (peak_r > ctrl_pd_threshold) &&
        (peak_r > ctrl_clipping_threshold)) begin
      s     = c + 2;
      found = 1'b0;
      for (int i = 0; i < NC; i++) begin
        if (!found && next_free[i] <= s) begin
          found        = 1'b1;
          exp_start[s] = one << i;
          exp_amp[s]   = peak_r - ctrl_clipping_threshold;
          exp_theta[s] = peak_theta;
          exp_phase[s] = peak_phase;
          for (int k = s; k < s + PL && k < MAXC; k++) exp_busy[k][i] = 1'b1;
          next_free[i] = s + PL;
        end
      end
      if (!found) drop_evt[s] = 1'b1;
    end
  endtask

  task automatic check_cycle(input int x);
    if (rst_evt[x] || clr_evt[x]) m_drop = 0;
    else if (drop_evt[x] && m_drop < 65535) m_drop++;
    chk("start", 32'(cpg_start), 32'(exp_start[x]));
    chk("amp",   32'(cpg_amp),   32'(exp_amp[x]));
    chk("theta", 32'(cpg_theta), 32'(exp_theta[x]));
    chk("phase", 32'(cpg_phase), 32'(exp_phase[x]));
    chk("busy",  32'(stat_busy), 32'(exp_busy[x]));
    chk("drop_cnt", 32'(stat_drop_cnt), 32'(exp_drop_cnt()));
  endtask

  task automatic drive(input logic v, input logic [DW:0] r, input logic [IT:0] th, input logic ph);
    peak_valid = v;
    peak_r     = r;
    peak_theta = th;
    peak_phase = ph;
    model(cyc);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (cyc < MAXC) check_cycle(cyc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 17'($urandom), 8'($urandom), 1'($urandom));
  endtask

  initial begin
    int d0;
    logic [DW:0] r;
    rst = 1'b1;
    peak_valid = 1'b0;
    peak_r = '0;
    peak_theta = '0;
    peak_phase = 1'b0;
    ctrl_enable = 1'b1;
    ctrl_pd_threshold = 17'h0800;
    ctrl_clipping_threshold = 17'h1000;
    stat_drop_clr = 1'b0;
    for (int i = 0; i < NC; i++) next_free[i] = 0;

    repeat (3) drive(1'b0, '0, '0, 1'b0);
    chk("reset_start", 32'(cpg_start), 32'h0);
    chk("reset_busy", 32'(stat_busy), 32'h0);
    rst = 1'b0;
    idle(2);

    // Single peak, two-cycle latency, clipped amplitude.
    drive(1'b1, 17'h1400, 8'h5A, 1'b1);
    idle(1);
    chk("single_start", 32'(cpg_start), 32'h1);
    chk("single_amp", 32'(cpg_amp), 32'h0400);
    chk("single_theta", 32'(cpg_theta), 32'h5A);
    idle(1);
    chk("single_zero_amp", 32'(cpg_amp), 32'h0);

    // Five back-to-back peaks with four slots.
    idle(PL + 2);
    d0 = m_drop;
    drive(1'b1, 17'h1401, 8'h01, 1'b0);
    drive(1'b1, 17'h1402, 8'h02, 1'b1);
    chk("burst_s0", 32'(cpg_start), 32'h1);
    drive(1'b1, 17'h1403, 8'h03, 1'b0);
    chk("burst_s1", 32'(cpg_start), 32'h2);
    drive(1'b1, 17'h1404, 8'h04, 1'b1);
    chk("burst_s2", 32'(cpg_start), 32'h4);
    drive(1'b1, 17'h1405, 8'h05, 1'b0);
    chk("burst_s3", 32'(cpg_start), 32'h8);
    chk("burst_s3_amp", 32'(cpg_amp), 32'h0404);
    idle(1);
    chk("burst_none", 32'(cpg_start), 32'h0);
`ifdef CFR_PA_DROP_CNT_EN
    chk("burst_drop", 32'(stat_drop_cnt), 32'(d0 + 1));
`else
    chk("burst_drop", 32'(stat_drop_cnt), 32'(d0 * 0));
`endif

    // Above detection but below clipping: discarded, not a drop.
    idle(PL + 2);
    d0 = m_drop;
    drive(1'b1, 17'h0C00, 8'h11, 1'b0);
    idle(1);
    chk("below_clip_start", 32'(cpg_start), 32'h0);
    chk("below_clip_busy", 32'(stat_busy), 32'h0);
    chk("below_clip_drop", 32'(m_drop), 32'(d0));

    // Slot reuse boundary: start at t, next landings at t+PL-1 and t+PL.
    idle(PL + 2);
    drive(1'b1, 17'h1500, 8'h21, 1'b0);
    idle(PL - 2);
    drive(1'b1, 17'h1600, 8'h22, 1'b1);
    drive(1'b1, 17'h1700, 8'h23, 1'b0);
    chk("reuse_early_slot1", 32'(cpg_start), 32'h2);
    idle(1);
    chk("reuse_exact_slot0", 32'(cpg_start), 32'h1);
    chk("reuse_exact_amp", 32'(cpg_amp), 32'h0700);

    // Enable low: no allocation.
    idle(PL + 2);
    ctrl_enable = 1'b0;
    drive(1'b1, 17'h1800, 8'h31, 1'b1);
    ctrl_enable = 1'b1;
    idle(1);
    chk("disabled_start", 32'(cpg_start), 32'h0);

    // Reset one cycle after a peak discards it.
    idle(2);
    drive(1'b1, 17'h1900, 8'h41, 1'b0);
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    chk("rst_mid_start", 32'(cpg_start), 32'h0);
    chk("rst_mid_busy", 32'(stat_busy), 32'h0);
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    chk("rst_after_start", 32'(cpg_start), 32'h0);

    // Randomized traffic around the thresholds.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        ctrl_pd_threshold       = 17'($urandom_range(0, 32'h1800));
        ctrl_clipping_threshold = 17'($urandom_range(0, 32'h1800));
      end
      ctrl_enable   = ($urandom_range(0, 9) != 0);
      stat_drop_clr = ($urandom_range(0, 29) == 0);
      rst           = ($urandom_range(0, 299) == 0);
      case ($urandom_range(0, 7))
        0:       r = ctrl_clipping_threshold;
        1:       r = ctrl_clipping_threshold + 17'd1;
        2:       r = ctrl_pd_threshold;
        3:       r = ctrl_pd_threshold + 17'd1;
        4:       r = 17'($urandom);
        default: r = 17'($urandom_range(0, 32'h2000));
      endcase
      drive(($urandom_range(0, 3) != 0), r, 8'($urandom), 1'($urandom));
    end
    rst = 1'b0;
    stat_drop_clr = 1'b0;
    ctrl_enable = 1'b1;
    ctrl_pd_threshold = 17'h0800;
    ctrl_clipping_threshold = 17'h1000;
    idle(PL + 2);

`ifdef CFR_PA_DROP_CNT_EN
    // Saturation, then a clear that coincides with drops.
    while (m_drop < 65535 && cyc < MAXC - PL - 20)
      drive(1'b1, 17'h1F00, 8'($urandom), 1'($urandom));
    repeat (4) drive(1'b1, 17'h1F00, 8'($urandom), 1'($urandom));
    chk("drop_saturated", 32'(stat_drop_cnt), 32'hFFFF);
    drive(1'b1, 17'h1F00, 8'h55, 1'b0);
    stat_drop_clr = 1'b1;
    drive(1'b1, 17'h1F00, 8'h56, 1'b1);
    stat_drop_clr = 1'b0;
    chk("drop_clr_priority", 32'(stat_drop_cnt), 32'h0);
    idle(2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
